// File: rtl/cargador_instrucciones.sv
// Byte-stream loader that assembles 32-bit instruction words and writes them into instruction memory.
// Optional trailing XOR checksum byte enabled by defining CARGADOR_CHECKSUM_EN.
module cargador_instrucciones #(
    parameter int          MAX_WORDS  = 64,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] num_words,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        cpu_hold
`ifdef CARGADOR_CHECKSUM_EN
    ,
    output logic        chk_err
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        FIN
`ifdef CARGADOR_CHECKSUM_EN
        ,
        CHK
`endif
    } state_t;

    state_t      state, state_next;
    logic [1:0]  byte_cnt;
    logic [15:0] words_left;
    logic [15:0] words_clamped;
    logic [31:0] asm_word;
    logic [1:0]  lane;
    logic        accept;
`ifdef CARGADOR_CHECKSUM_EN
    logic [7:0]  xor_acc;
`endif

    assign words_clamped = (num_words > 16'(MAX_WORDS)) ? 16'(MAX_WORDS) : num_words;
    assign lane          = BIG_ENDIAN ? (2'd3 - byte_cnt) : byte_cnt;
    assign accept        = byte_valid && byte_ready;
    assign busy          = (state != IDLE);
    assign wr_data       = asm_word;

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        wr_en      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = (words_clamped == 16'd0) ? FIN : RECV;
            end
            RECV: begin
                byte_ready = 1'b1;
                if (byte_valid && byte_cnt == 2'd3) state_next = WRITE;
            end
            WRITE: begin
                wr_en = 1'b1;
                // words_left decrements on this same edge, so 1 here means the last word
                if (words_left == 16'd1) begin
`ifdef CARGADOR_CHECKSUM_EN
                    state_next = CHK;
`else
                    state_next = FIN;
`endif
                end else begin
                    state_next = RECV;
                end
            end
`ifdef CARGADOR_CHECKSUM_EN
            CHK: begin
                byte_ready = 1'b1;
                if (byte_valid) state_next = FIN;
            end
`endif
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            byte_cnt   <= 2'd0;
            words_left <= 16'd0;
            asm_word   <= 32'd0;
            wr_addr    <= BASE_ADDR;
            done       <= 1'b0;
            cpu_hold   <= 1'b1;
`ifdef CARGADOR_CHECKSUM_EN
            xor_acc    <= 8'd0;
            chk_err    <= 1'b0;
`endif
        end else begin
            state <= state_next;
            done  <= (state == FIN);
            case (state)
                IDLE: begin
                    if (start) begin
                        words_left <= words_clamped;
                        wr_addr    <= BASE_ADDR;
                        byte_cnt   <= 2'd0;
                        cpu_hold   <= 1'b1;
`ifdef CARGADOR_CHECKSUM_EN
                        xor_acc    <= 8'd0;
                        chk_err    <= 1'b0;
`endif
                    end
                end
                RECV: begin
                    if (accept) begin
                        asm_word[{lane, 3'b000} +: 8] <= byte_in;
                        byte_cnt                      <= byte_cnt + 2'd1;
`ifdef CARGADOR_CHECKSUM_EN
                        xor_acc                       <= xor_acc ^ byte_in;
`endif
                    end
                end
                WRITE: begin
                    wr_addr    <= wr_addr + 32'd4;
                    words_left <= words_left - 16'd1;
                    byte_cnt   <= 2'd0;
                end
`ifdef CARGADOR_CHECKSUM_EN
                CHK: begin
                    if (accept) chk_err <= (byte_in != xor_acc);
                end
                FIN:     cpu_hold <= chk_err;
`else
                FIN:     cpu_hold <= 1'b0;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cargador_instrucciones.sv
// Randomized self-checking bench: a big-endian and a little-endian loader share one byte stream
// and are compared against a queue-based model of the expected memory writes.
module tb_cargador_instrucciones;

    localparam int          MAXW    = 4;
    localparam logic [31:0] BASE_BE = 32'h0000_0000;
    localparam logic [31:0] BASE_LE = 32'hFFFF_FFF8;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_words;
    logic [7:0]  byte_in;
    logic        byte_valid;

    logic        rdy_be, wen_be, busy_be, done_be, hold_be;
    logic [31:0] addr_be, data_be;
    logic        rdy_le, wen_le, busy_le, done_le, hold_le;
    logic [31:0] addr_le, data_le;
`ifdef CARGADOR_CHECKSUM_EN
    logic        cerr_be, cerr_le;
`endif

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          start_cyc;
    int          done_cnt;
    int          done_cyc;
    logic        hold_at_done;
    logic [63:0] q_be[$];
    logic [63:0] q_le[$];

    cargador_instrucciones #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE_BE), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rst(rst), .start(start), .num_words(num_words),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(rdy_be),
        .wr_en(wen_be), .wr_addr(addr_be), .wr_data(data_be),
        .busy(busy_be), .done(done_be), .cpu_hold(hold_be)
`ifdef CARGADOR_CHECKSUM_EN
        , .chk_err(cerr_be)
`endif
    );

    cargador_instrucciones #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE_LE), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst(rst), .start(start), .num_words(num_words),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(rdy_le),
        .wr_en(wen_le), .wr_addr(addr_le), .wr_data(data_le),
        .busy(busy_le), .done(done_le), .cpu_hold(hold_le)
`ifdef CARGADOR_CHECKSUM_EN
        , .chk_err(cerr_le)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wen_be) q_be.push_back({addr_be, data_be});
        if (wen_le) q_le.push_back({addr_le, data_le});
        if (done_be) begin
            done_cnt++;
            done_cyc     = cyc;
            hold_at_done = hold_be;
        end
    end

    // Expected memory image: word w is built from bytes 4w..4w+3 in arrival order.
    function automatic logic [63:0] model_write(bq_t b, int w, bit big, logic [31:0] base);
        logic [31:0] word;
        if (big) word = {b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]};
        else     word = {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]};
        return {base + 32'(4 * w), word};
    endfunction

    function automatic int exp_latency(int n);
`ifdef CARGADOR_CHECKSUM_EN
        return (n == 0) ? 2 : 5 * n + 3;
`else
        return 5 * n + 2;
`endif
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] n);
        start     = 1'b1;
        num_words = n;
        start_cyc = cyc;
        tick(1);
        start = 1'b0;
    endtask

    // Presents one byte and holds it until the loader takes it.
    task automatic send_byte(input logic [7:0] b);
        bit acc = 1'b0;
        int n   = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = rdy_be;
            tick(1);
            n++;
        end
        byte_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_byte timeout: byte %h not accepted within 200 cycles", b);
        end
    endtask

    task automatic send_trailer(input bq_t b, input int n);
`ifdef CARGADOR_CHECKSUM_EN
        logic [7:0] x = 8'd0;
        for (int i = 0; i < n; i++) x ^= b[i];
        send_byte(x);
`else
        if (n < 0 || b.size() < 0) tick(0);
`endif
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && done_cnt == 0; i++) tick(1);
        if (done_cnt == 0) begin
            checks++;
            errors++;
            $display("FAIL wait_done timeout: done never pulsed within 200 cycles");
        end
    endtask

    task automatic compare_writes(input bq_t b, input int eff);
        checks++;
        if (q_be.size() != eff) begin
            errors++;
            $display("FAIL be_write_count got=%0d exp=%0d", q_be.size(), eff);
        end
        checks++;
        if (q_le.size() != eff) begin
            errors++;
            $display("FAIL le_write_count got=%0d exp=%0d", q_le.size(), eff);
        end
        for (int w = 0; w < eff && w < q_be.size(); w++) begin
            checks++;
            if (q_be[w] !== model_write(b, w, 1'b1, BASE_BE)) begin
                errors++;
                $display("FAIL be_write[%0d] got=%h exp=%h", w, q_be[w], model_write(b, w, 1'b1, BASE_BE));
            end
        end
        for (int w = 0; w < eff && w < q_le.size(); w++) begin
            checks++;
            if (q_le[w] !== model_write(b, w, 1'b0, BASE_LE)) begin
                errors++;
                $display("FAIL le_write[%0d] got=%h exp=%h", w, q_le[w], model_write(b, w, 1'b0, BASE_LE));
            end
        end
    endtask

    // Full load: bytes beyond the clamped word count are offered but must never be taken.
    task automatic run_load(input int n_req, input bq_t b, input int max_gap, input bit chk_lat);
        int eff = (n_req > MAXW) ? MAXW : n_req;
        q_be.delete();
        q_le.delete();
        done_cnt = 0;
        pulse_start(16'(n_req));
        checks++;
        if (hold_be !== 1'b1 || busy_be !== 1'b1) begin
            errors++;
            $display("FAIL load_start hold/busy got=%b%b exp=11", hold_be, busy_be);
        end
        for (int i = 0; i < eff * 4; i++) begin
            tick($urandom_range(0, max_gap));
            send_byte(b[i]);
        end
        if (eff > 0) send_trailer(b, eff * 4);
        if (b.size() > eff * 4) begin
            byte_in    = b[eff*4];
            byte_valid = 1'b1;
        end
        wait_done();
        tick(5);
        byte_valid = 1'b0;
        compare_writes(b, eff);
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL done_pulses got=%0d exp=1", done_cnt);
        end
        checks++;
        if (hold_at_done !== 1'b0 || hold_be !== 1'b0 || busy_be !== 1'b0) begin
            errors++;
            $display("FAIL post_load hold_at_done/hold/busy got=%b%b%b exp=000", hold_at_done, hold_be, busy_be);
        end
        if (chk_lat) begin
            checks++;
            if (done_cyc - start_cyc != exp_latency(eff)) begin
                errors++;
                $display("FAIL latency got=%0d exp=%0d", done_cyc - start_cyc, exp_latency(eff));
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if ({wen_be, rdy_be, busy_be, done_be, hold_be} !== 5'b00001 ||
            {wen_le, rdy_le, busy_le, done_le, hold_le} !== 5'b00001) begin
            errors++;
            $display("FAIL %s ctrl got=%b/%b exp=00001", tag,
                     {wen_be, rdy_be, busy_be, done_be, hold_be}, {wen_le, rdy_le, busy_le, done_le, hold_le});
        end
        checks++;
        if (addr_be !== BASE_BE || addr_le !== BASE_LE || data_be !== 32'd0 || data_le !== 32'd0) begin
            errors++;
            $display("FAIL %s addr/data got=%h %h %h %h exp=%h %h 0 0", tag,
                     addr_be, addr_le, data_be, data_le, BASE_BE, BASE_LE);
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        start      = 1'b0;
        num_words  = 16'd0;
        byte_in    = 8'd0;
        byte_valid = 1'b0;
        #3;
        check_reset_values("reset");
        tick(3);
        @(negedge clk);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_basic();
        bq_t b = '{8'h00, 8'hA6, 8'h08, 8'h20, 8'h8C, 8'h22, 8'h00, 8'h04};
        run_load(2, b, 0, 1'b1);
        checks++;
        if (q_be.size() != 2 || q_be[0] !== {32'h0, 32'h00A60820} || q_be[1] !== {32'h4, 32'h8C220004}) begin
            errors++;
            $display("FAIL basic_be_words got=%p exp=0:00A60820 4:8C220004", q_be);
        end
        checks++;
        if (q_le.size() == 0 || q_le[0][31:0] !== 32'h2008A600) begin
            errors++;
            $display("FAIL basic_le_word got=%p exp=2008A600 first", q_le);
        end
    endtask

    task automatic test_zero_words();
        bq_t b = '{};
        run_load(0, b, 0, 1'b1);
    endtask

    task automatic test_stall_and_ignored_start();
        bq_t b = '{8'h00, 8'hA6, 8'h08, 8'h20, 8'h8C, 8'h22, 8'h00, 8'h04};
        q_be.delete();
        q_le.delete();
        done_cnt = 0;
        pulse_start(16'd2);
        send_byte(b[0]);
        send_byte(b[1]);
        tick(4);
        pulse_start(16'd7);
        tick(5);
        checks++;
        if (q_be.size() != 0 || q_le.size() != 0 || busy_be !== 1'b1) begin
            errors++;
            $display("FAIL stall_no_write got=%0d/%0d busy=%b exp=0/0 busy=1", q_be.size(), q_le.size(), busy_be);
        end
        for (int i = 2; i < 8; i++) send_byte(b[i]);
        send_trailer(b, 8);
        wait_done();
        tick(3);
        compare_writes(b, 2);
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL stall_done_pulses got=%0d exp=1", done_cnt);
        end
    endtask

    task automatic test_reset_mid_load();
        bq_t b;
        bq_t r;
        for (int i = 0; i < 8; i++) b.push_back(8'($urandom));
        for (int i = 0; i < 4; i++) r.push_back(8'($urandom));
        done_cnt = 0;
        pulse_start(16'd2);
        for (int i = 0; i < 6; i++) send_byte(b[i]);
        rst = 1'b1;
        #2;
        check_reset_values("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        q_be.delete();
        q_le.delete();
        byte_in    = b[6];
        byte_valid = 1'b1;
        tick(10);
        byte_valid = 1'b0;
        checks++;
        if (q_be.size() != 0 || q_le.size() != 0 || done_cnt != 0 || hold_be !== 1'b1) begin
            errors++;
            $display("FAIL after_reset writes=%0d/%0d done=%0d hold=%b exp=0/0 0 1",
                     q_be.size(), q_le.size(), done_cnt, hold_be);
        end
        run_load(1, r, 0, 1'b1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            bq_t b;
            int  n = $urandom_range(1, MAXW);
            for (int i = 0; i < 4 * n; i++) b.push_back(8'($urandom));
            run_load(n, b, 3, 1'b0);
        end
    endtask

    task automatic test_clamp();
        bq_t b;
        for (int i = 0; i < 24; i++) b.push_back(8'($urandom));
        run_load(6, b, 0, 1'b1);
    endtask

`ifdef CARGADOR_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] ck[2] = '{8'h04, 8'h05};
        for (int k = 0; k < 2; k++) begin
            done_cnt = 0;
            pulse_start(16'd1);
            send_byte(8'h01);
            send_byte(8'h02);
            send_byte(8'h03);
            send_byte(8'h04);
            send_byte(ck[k]);
            wait_done();
            tick(4);
            checks++;
            if (cerr_be !== 1'(k) || cerr_le !== 1'(k) || hold_be !== 1'(k)) begin
                errors++;
                $display("FAIL checksum[%0d] chk_err=%b/%b hold=%b exp=%0d", k, cerr_be, cerr_le, hold_be, k);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_words();
        test_stall_and_ignored_start();
        test_reset_mid_load();
        test_random();
        test_clamp();
`ifdef CARGADOR_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cargador_instrucciones.md
Name: cargador_instrucciones

Overview:
- Writer-side counterpart to the instruction memory read by the fetch cycle (PC -> InstructionMem -> Adder).
- Accepts a byte stream over a valid/ready handshake and assembles bytes into 32-bit MIPS instruction words.
- Writes each word into instruction memory at consecutive word-aligned addresses.
- Holds the processor (PC) off until the program image is fully loaded.

Parameters:
- MAX_WORDS, 64, capacity of the instruction memory in words; longer loads are clamped.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be a multiple of 4.
- BIG_ENDIAN, 1, 1 = first received byte goes to [31:24]; 0 = first byte goes to [7:0].

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse that begins a load; sampled only in IDLE.
- num_words  in  16  number of words to load; sampled on start.
- byte_in  in  8  incoming byte.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  instruction memory write strobe, one cycle per word.
- wr_addr  out  32  byte address of the word being written.
- wr_data  out  32  assembled instruction word.
- busy  out  1  a load is in progress.
- done  out  1  one-cycle pulse when the final word has been written.
- cpu_hold  out  1  keeps the PC at BASE_ADDR while high.

Behaviour:
- Reset (asynchronous):
  - state = IDLE; byte counter, word counter and assembly register = 0.
  - wr_en = 0, wr_addr = BASE_ADDR, wr_data = 0.
  - byte_ready = 0, busy = 0, done = 0, cpu_hold = 1.
- FSM states: IDLE, RECV, WRITE, FIN.
- IDLE:
  - On start: latch words_left = min(num_words, MAX_WORDS) and set wr_addr = BASE_ADDR.
  - If words_left == 0, go to FIN; otherwise go to RECV.
  - cpu_hold goes high on start and stays high until FIN.
- RECV:
  - byte_ready = 1; a byte is accepted when byte_valid && byte_ready.
  - Each accepted byte is placed in the assembly register lane selected by the byte counter (0..3) and BIG_ENDIAN.
  - On the 4th accepted byte, go to WRITE.
- WRITE (exactly one cycle):
  - wr_en = 1 and byte_ready = 0; wr_data holds the assembled word and wr_addr the current address.
  - Next cycle: wr_addr += 4 (wraps modulo 2^32), words_left -= 1, byte counter cleared.
  - If words_left reaches 0, go to FIN; otherwise go back to RECV.
- FIN (one cycle):
  - done = 1, cpu_hold falls to 0, busy falls, then go to IDLE.
- Latency: 4 accepted bytes plus 1 write cycle per word.
  - Minimum total = 5*N + 2 cycles from start to the done pulse.
- busy = 1 in RECV, WRITE and FIN.
- Boundary conditions:
  - start while busy is ignored.
  - byte_valid while not in RECV is not accepted; the sender must hold the byte.
  - byte_valid gaps stall assembly with no timeout.
  - Reset mid-load discards the partial word; no write is issued and cpu_hold returns to 1.
  - num_words > MAX_WORDS is clamped; excess bytes are never accepted.
  - After FIN the loader returns to IDLE, and a new start reloads from BASE_ADDR.

Optional Feature:
- Macro: CARGADOR_CHECKSUM_EN.
- Enabled:
  - After the last WRITE, add state CHK: accept one extra byte and compare it against the running XOR of all accepted data bytes.
  - Add output chk_err (1 bit, reset 0), valid while done = 1 and held until the next start.
  - On mismatch, cpu_hold stays 1 after FIN until the next start.
- Disabled:
  - No CHK state and no chk_err port; WRITE of the last word goes directly to FIN.

Test Plan:
- Reset then start with num_words=2 and bytes 00 A6 08 20, 8C 22 00 04 (BIG_ENDIAN=1) -> wr_en pulses twice.
  - First write: wr_addr=0, wr_data=32'h00A60820.
  - Second write: wr_addr=4, wr_data=32'h8C220004.
  - done pulses once and cpu_hold falls in the same cycle.
- Same stream with BIG_ENDIAN=0 -> first wr_data=32'h2008A600.
- start with num_words=0 -> no wr_en; done one cycle after FIN entry (2 cycles after start); cpu_hold returns to 0.
- byte_valid deasserted for 10 cycles after the 2nd byte -> no write; assembled word is unchanged once bytes resume.
  - start pulsed during the load is ignored; word count is unchanged.
- rst asserted after 6 of 8 bytes -> outputs return to reset values immediately and no further wr_en occurs.
  - A new start with num_words=1 writes at BASE_ADDR.
- With CARGADOR_CHECKSUM_EN, one word 01 02 03 04 followed by checksum byte 04 -> chk_err=0.
  - Checksum byte 05 -> chk_err=1 and cpu_hold stays 1.
